pll_lock_sequencer: RTL
=======================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before release.
REQ-002 SHALL have parameter PLL_RESET_CYCLES, default 16: pll_areset pulse length in cycles.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum WAIT_LOCK dwell in cycles.
REQ-004 SHALL have parameter LOSS_CNT_W, default 8: lock-loss counter width.
REQ-005 SHALL have port clk_in, input, 1: free-running reference clock, also the PLL input clock; the only clock.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port pll_locked, input, 1: raw PLL lock flag, asynchronous to clk_in.
REQ-008 SHALL have port relock_req, input, 1: single-cycle request to re-reset the PLL.
REQ-009 SHALL have port pll_areset, output, 1: PLL reset, active-high.
REQ-010 SHALL have port sys_rst_n, output, 1: reset for logic on the five PLL phase clocks, active-low.
REQ-011 SHALL have port ready, output, 1: phases are stable and usable.
REQ-012 SHALL have port timeout_err, output, 1: sticky lock-timeout flag.
REQ-013 SHALL have port loss_count, output, LOSS_CNT_W: saturating count of lock losses.
REQ-014 SHALL have port state, output, 2: FSM state (RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3).

Function
REQ-015 SHALL synchronize pll_locked through a two-flop synchronizer on clk_in (lock_s); all FSM decisions use lock_s only, so input-to-decision latency is 2 cycles.
REQ-016 SHALL use one cycle counter sized clog2 of the largest parameter plus 1 bit, and SHALL clear it on every state transition.
REQ-017 In RESET_PLL: pll_areset=1; after PLL_RESET_CYCLES cycles, go to WAIT_LOCK.
REQ-018 In WAIT_LOCK: pll_areset=0; lock_s=1 goes to STABILIZE; counter reaching LOCK_TIMEOUT_CYCLES-1 with lock_s=0 goes to RESET_PLL and sets timeout_err.
REQ-019 In STABILIZE: lock_s=0 goes to WAIT_LOCK and is not counted as a loss; after LOCK_STABLE_CYCLES consecutive cycles with lock_s=1, go to RUN.
REQ-020 In RUN: lock_s=0 goes to RESET_PLL and increments loss_count; relock_req=1 with lock_s=1 goes to RESET_PLL with no increment; if both occur in the same cycle, the event is counted as a loss.
REQ-021 relock_req SHALL be ignored outside RUN.
REQ-022 All outputs SHALL be registered: sys_rst_n=1 and ready=1 exactly while state=RUN, asserted the cycle state enters RUN and dropped the cycle state leaves it.
REQ-023 loss_count SHALL saturate at all-ones and never wrap.
REQ-024 timeout_err SHALL stay set until reset_n is asserted; later successful locks do not clear it.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state=RESET_PLL, pll_areset=1, sys_rst_n=0, ready=0, timeout_err=0, loss_count=0, counter=0, synchronizer=0.
REQ-026 On reset_n release, the full PLL_RESET_CYCLES pulse SHALL be produced before WAIT_LOCK, including after a mid-RUN or mid-STABILIZE reset.

Configuration
REQ-027 Macro PLL_SEQ_LOSS_COUNT_EN defined: loss counter implemented per REQ-020/023; undefined: loss_count tied to 0, no counter logic, and FSM behaviour otherwise identical.

Verification (LOCK_STABLE_CYCLES=8, PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, macro defined)
REQ-028 Release reset_n, raise pll_locked at cycle 10 -> pll_areset high cycles 0-3; RUN, sys_rst_n=1, and ready=1 at cycle 10+2+8 = 20 (±1 for the entry register).
REQ-029 Locked from cycle 10, drop pll_locked for 1 cycle during STABILIZE -> return to WAIT_LOCK, loss_count stays 0, the 8-cycle window restarts.
REQ-030 Keep pll_locked=0 -> timeout_err=1 after 4+32 cycles, pll_areset re-pulses for 4 cycles, and this repeats; timeout_err remains 1 after a later lock reaches RUN.
REQ-031 In RUN, drop pll_locked 300 times -> loss_count = 255 (saturated), sys_rst_n low within 3 cycles of each drop; relock_req in RUN -> RESET_PLL and loss_count unchanged.
REQ-032 Assert reset_n=0 mid-RUN asynchronously -> sys_rst_n=0 and pll_areset=1 immediately, with no clock edge required; all counters are 0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_areset, qualifies lock, releases sys_rst_n.
// Optional feature: define PLL_SEQ_LOSS_COUNT_EN to implement the lock-loss counter.
module pll_lock_sequencer #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_areset,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  timeout_err,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [1:0]            state
);

    localparam int MAX_AB = (LOCK_STABLE_CYCLES > PLL_RESET_CYCLES)
                          ? LOCK_STABLE_CYCLES : PLL_RESET_CYCLES;
    localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT_CYCLES)
                          ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABILIZE = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, lock_s_q;
    logic             areset_q, srst_n_q, ready_q;
    logic             timeout_q, timeout_d;

    // Two-flop synchronizer for the asynchronous lock flag
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    // Next-state, shared dwell counter and sticky timeout decision
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        timeout_d = timeout_q;
        unique case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_RESET_PLL;
                    timeout_d = 1'b1;
                end
            end
            S_STABILIZE: begin
                if (!lock_s_q) state_d = S_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!lock_s_q || relock_req) state_d = S_RESET_PLL;
            end
            default: state_d = S_RESET_PLL;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // State, counter and outputs registered from the next state
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            areset_q  <= 1'b1;
            srst_n_q  <= 1'b0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            areset_q  <= (state_d == S_RESET_PLL);
            srst_n_q  <= (state_d == S_RUN);
            ready_q   <= (state_d == S_RUN);
            timeout_q <= timeout_d;
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  loss_ev;

    // A loss is RUN with lock gone, whether or not relock_req is also high
    assign loss_ev = (state_q == S_RUN) && !lock_s_q;

    // Saturating increment of the loss count
    always_comb begin
        loss_d = loss_q;
        if (loss_ev && (loss_q != {LOSS_CNT_W{1'b1}})) loss_d = loss_q + 1'b1;
    end

    // Loss counter register
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) loss_q <= '0;
        else          loss_q <= loss_d;
    end

    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

    assign pll_areset  = areset_q;
    assign sys_rst_n   = srst_n_q;
    assign ready       = ready_q;
    assign timeout_err = timeout_q;
    assign state       = state_q;

endmodule
